// File: rtl/sensor_move_detector.sv
// Debounces 32-bit occupancy snapshots into a stable board image, then scans the
// change mask one square per cycle and queues LIFT/PLACE events in a small FIFO.
module sensor_move_detector #(
  parameter int STABLE_COUNT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] snap_in,
  input  logic        snap_valid,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [1:0]  ev_type,
  output logic [4:0]  ev_square,
  output logic [31:0] stable_board,
  output logic [5:0]  piece_count,
  output logic        busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [3:0]    SC    = 4'(STABLE_COUNT);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [1:0]    LIFT  = 2'b01;
  localparam logic [1:0]    PLACE = 2'b10;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   board_q, board_d;
  logic [31:0]   diff_q, diff_d;
  logic [5:0]    pc_q, pc_d;
  logic [4:0]    idx_q, idx_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ev_valid_q, ev_valid_d;
  logic [6:0]    head_q, head_d;
  logic [6:0]    mem_q [FIFO_DEPTH];

  logic          commit, pop, push_req, push_ok, push, stall;
  logic [6:0]    entry;
  logic [CW-1:0] remain;

  function automatic logic [5:0] popcnt(input logic [31:0] v);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 32; i++) s = s + 6'(v[i]);
    return s;
  endfunction

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (snap_valid) begin
      if (snap_in == cand_q) begin
        if (cnt_q != SC) cnt_d = cnt_q + 4'd1;
      end else begin
        cand_d = snap_in;
        cnt_d  = 4'd1;
      end
    end
  end

  always_comb begin
    commit   = (state_q == IDLE) && (cnt_q == SC) && (cand_q != board_q);
    pop      = (count_q != '0) && ev_ready;
    push_req = (state_q == SCAN) && diff_q[idx_q];
    push_ok  = (count_q < DEPTH) || pop;
    push     = push_req && push_ok;
    stall    = push_req && !push_ok;
    entry    = {board_q[idx_q] ? PLACE : LIFT, idx_q};

    state_d = state_q;
    board_d = board_q;
    diff_d  = diff_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    if (commit) begin
      board_d = cand_q;
      diff_d  = cand_q ^ board_q;
      pc_d    = popcnt(cand_q);
      idx_d   = 5'd0;
      state_d = SCAN;
    end else if ((state_q == SCAN) && !stall) begin
      idx_d = idx_q + 5'd1;
      if (idx_q == 5'd31) state_d = IDLE;
    end
  end

  // Head register tracks the entry that will sit at the read pointer after this edge;
  // a push into an otherwise-empty FIFO bypasses memory so it shows up one edge later.
  always_comb begin
    wr_d       = push ? wr_q + PW'(1) : wr_q;
    rd_d       = pop  ? rd_q + PW'(1) : rd_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    remain     = count_q - CW'(pop);
    ev_valid_d = (count_d != '0);
    if (count_d == '0)      head_d = '0;
    else if (remain == '0)  head_d = entry;
    else                    head_d = mem_q[rd_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      board_q    <= '0;
      diff_q     <= '0;
      pc_q       <= '0;
      idx_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      ev_valid_q <= 1'b0;
      head_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      board_q    <= board_d;
      diff_q     <= diff_d;
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      ev_valid_q <= ev_valid_d;
      head_q     <= head_d;
      if (push) mem_q[wr_q] <= entry;
    end
  end

  assign ev_valid     = ev_valid_q;
  assign ev_type      = head_q[6:5];
  assign ev_square    = head_q[4:0];
  assign stable_board = board_q;
  assign piece_count  = pc_q;
  assign busy         = (state_q == SCAN);

endmodule

// File: tb/tb_sensor_move_detector.sv
// Directed bench for sensor_move_detector: debounce/commit timing, event order,
// FIFO backpressure, deferred commit and asynchronous reset mid-scan.
module tb_sensor_move_detector;

  logic        clk, reset;
  logic [31:0] snap_in;
  logic        snap_valid;
  logic        ev_valid, ev_ready;
  logic [1:0]  ev_type;
  logic [4:0]  ev_square;
  logic [31:0] stable_board;
  logic [5:0]  piece_count;
  logic        busy;

  int n_cmp, n_err, busy_cyc;
  logic [6:0] logq[$];
  logic [6:0] expq[$];

  sensor_move_detector #(.STABLE_COUNT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .snap_in(snap_in), .snap_valid(snap_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_square(ev_square), .stable_board(stable_board),
    .piece_count(piece_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted events are whatever sits at the head when ev_valid && ev_ready at an edge.
  always @(posedge clk) begin
    if (!reset && ev_valid && ev_ready) logq.push_back({ev_type, ev_square});
    if (busy) busy_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] v);
    snap_in    = v;
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_n"}, logq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < logq.size()) chk($sformatf("%s_%0d", tag, i), logq[i], expq[i]);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; busy_cyc = 0;
    reset = 1'b1; snap_in = '0; snap_valid = 1'b0; ev_ready = 1'b1;
    #3;
    chk("rst_board", stable_board, 0);
    chk("rst_pc", piece_count, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_type", ev_type, 0);
    chk("rst_sq", ev_square, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 1: commit after 4th strobe, two PLACE events, 32 busy cycles
    logq.delete();
    repeat (3) strobe(32'h5);
    tick();
    chk("t1_nocommit", stable_board, 0);
    strobe(32'h5);
    chk("t1_notyet", stable_board, 0);
    tick();
    busy_cyc = 0;
    chk("t1_board", stable_board, 32'h5);
    chk("t1_pc", piece_count, 2);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_lat_valid", ev_valid, 1);
    chk("t1_lat_head", {ev_type, ev_square}, 7'h40);
    wait_idle("t1_idle");
    repeat (3) tick();
    chk("t1_busycyc", busy_cyc, 32);
    expq = {};
    expq.push_back(7'h40); expq.push_back(7'h42);
    check_events("t1_ev");

    // 2: interrupted debounce commits once, no square 1
    do_reset();
    logq.delete();
    strobe(32'h5); strobe(32'h5); strobe(32'h7);
    tick();
    chk("t2_after7", stable_board, 0);
    strobe(32'h5); strobe(32'h5); strobe(32'h5);
    tick();
    chk("t2_three", stable_board, 0);
    strobe(32'h5);
    tick();
    chk("t2_board", stable_board, 32'h5);
    wait_idle("t2_idle");
    repeat (3) tick();
    check_events("t2_ev");

    // 3: backpressure stalls scan at idx 4, nothing lost
    do_reset();
    logq.delete();
    ev_ready = 1'b0;
    repeat (4) strobe(32'h3F);
    tick();
    chk("t3_board", stable_board, 32'h3F);
    chk("t3_pc", piece_count, 6);
    repeat (10) tick();
    chk("t3_valid", ev_valid, 1);
    chk("t3_head", {ev_type, ev_square}, 7'h40);
    chk("t3_busy", busy, 1);
    chk("t3_idx", dut.idx_q, 4);
    ev_ready = 1'b1;
    wait_idle("t3_idle");
    repeat (3) tick();
    expq = {};
    for (int k = 0; k < 6; k++) expq.push_back(7'h40 | 7'(k));
    check_events("t3_ev");
    chk("t3_empty", ev_valid, 0);

    // 4 + 5: LIFT/PLACE ordering, then a commit deferred until scan ends
    do_reset();
    repeat (4) strobe(32'h1);
    tick();
    wait_idle("t4_pre_idle");
    repeat (3) tick();
    logq.delete();
    repeat (4) strobe(32'h2);
    tick();
    chk("t4_board", stable_board, 32'h2);
    chk("t4_pc", piece_count, 1);
    repeat (4) strobe(32'h6);
    tick();
    chk("t5_deferred", stable_board, 32'h2);
    chk("t5_busy", busy, 1);
    wait_idle("t5_idle1");
    chk("t5_idle_board", stable_board, 32'h2);
    tick();
    chk("t5_board", stable_board, 32'h6);
    chk("t5_pc", piece_count, 2);
    chk("t5_rebusy", busy, 1);
    wait_idle("t5_idle2");
    repeat (3) tick();
    expq = {};
    expq.push_back(7'h20); expq.push_back(7'h41); expq.push_back(7'h42);
    check_events("t45_ev");

    // 6: asynchronous reset mid-scan with 3 events queued
    do_reset();
    ev_ready = 1'b0;
    repeat (4) strobe(32'h7);
    tick();
    repeat (6) tick();
    chk("t6_pre_valid", ev_valid, 1);
    chk("t6_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_valid", ev_valid, 0);
    chk("t6_board", stable_board, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pc", piece_count, 0);
    #1;
    reset = 1'b0;
    ev_ready = 1'b1;
    logq.delete();
    tick();
    repeat (4) strobe(32'h7);
    tick();
    chk("t6_reboard", stable_board, 32'h7);
    wait_idle("t6_idle");
    repeat (3) tick();
    expq = {};
    expq.push_back(7'h40); expq.push_back(7'h41); expq.push_back(7'h42);
    check_events("t6_ev");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
